pll_lock_supervisor: RTL

Sequences the reset and lock of the core PLL and gates the downstream core reset on a stable lock. Runs on the free-running 74.25 MHz reference clock, the only clock that is valid before the PLL locks. Drives the PLL reset, synchronises and qualifies its `locked` output, and retries a bounded number of times. Releases `core_reset_n` to the video and audio domains only after lock has been stable for a programmable interval.

---
 rtl/pll_lock_supervisor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Resets the core PLL, waits for it to lock, and releases the downstream core
//   reset only after the lock has stayed high for a programmable interval. A
//   failed attempt (no lock inside the timeout) is retried a bounded number of
//   times, after which the block parks in a sticky FAULT state. Everything runs
//   on the free-running 74.25 MHz reference clock, because that is the only
//   clock that is valid before the PLL locks.
//
// Parameters:
//   RST_PULSE_CYCLES    (1..255)       cycles pll_rst is held high per attempt
//   LOCK_TIMEOUT_CYCLES (1..2^20-1)    cycles allowed in WAIT_LOCK per attempt
//   LOCK_STABLE_CYCLES  (1..65535)     cycles lock must stay high before release
//   MAX_RETRIES         (0..15)        extra attempts before FAULT
//
// Ports:
//   clk_74a       in   74.25 MHz reference clock (sole clock)
//   reset_n       in   synchronous active-low reset
//   pll_locked    in   raw PLL locked, asynchronous to clk_74a
//   pll_rst       out  PLL reset, active-high, registered
//   core_reset_n  out  downstream reset, active-low, registered, high in RUN only
//   pll_ready     out  high in RUN only, registered
//   fault         out  high in FAULT only, registered
//   retry_count   out  failed attempts since reset_n release, saturates at 15
//   state_dbg     out  current FSM state encoding, for observation only
//                      (0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT)
//
// Build option:
//   PLL_SUP_RELOCK_EN  defined:   a lock loss in RUN starts a new full attempt
//                                 (RESET_PLL) and counts as a failed attempt.
//                      undefined: a lock loss in RUN goes straight to FAULT and
//                                 retry_count is left unchanged.
//
// Counter convention:
//   One 20-bit down-counter is reloaded on every state entry with
//   (duration - 1); a timed state is left on the edge that finds it at zero,
//   so the state lasts exactly "duration" cycles. Out of reset the counter is
//   loaded with RST_PULSE_CYCLES instead, because the first reset_n-high edge
//   itself is the first counted cycle of the pulse; pll_rst therefore falls
//   exactly RST_PULSE_CYCLES edges after that first edge.
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // Reload values: entry loads (duration - 1), see counter convention above.
  localparam logic [19:0] RST_INIT     = 20'(RST_PULSE_CYCLES);
  localparam logic [19:0] RST_LOAD     = 20'(RST_PULSE_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LOAD = 20'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [19:0] STABLE_LOAD  = 20'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  // ---------------------------------------------------------------------------
  // Lock synchroniser: pll_locked is asynchronous, only lock_s is used below.
  // ---------------------------------------------------------------------------
  logic lock_meta;
  logic lock_s;

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state, shared counter and retry counter
  // ---------------------------------------------------------------------------
  state_e      state;
  state_e      state_n;
  logic [19:0] cnt;
  logic [19:0] cnt_n;
  logic [3:0]  retry_n;
  logic        cnt_zero;
  logic [3:0]  retry_inc;
  logic        retries_spent;

  assign cnt_zero  = (cnt == 20'd0);
  assign retry_inc = (retry_count == 4'hF) ? 4'hF : (retry_count + 4'd1);
  // "Failed attempts now exceed MAX_RETRIES" after this failure is counted,
  // evaluated on the pre-increment value so that saturation at 15 cannot hide
  // the limit when MAX_RETRIES is 15.
  assign retries_spent = (retry_count >= RETRY_LIMIT);

  always_comb begin
    state_n = state;
    cnt_n   = cnt - 20'd1;
    retry_n = retry_count;

    case (state)
      RESET_PLL: begin
        if (cnt_zero) begin
          state_n = WAIT_LOCK;
          cnt_n   = TIMEOUT_LOAD;
        end
      end

      WAIT_LOCK: begin
        // Lock is tested first: a timeout expiring in the same cycle that
        // lock_s rises is resolved as a successful lock, not a retry.
        if (lock_s) begin
          state_n = STABILIZE;
          cnt_n   = STABLE_LOAD;
        end else if (cnt_zero) begin
          retry_n = retry_inc;
          if (retries_spent) begin
            state_n = FAULT;
            cnt_n   = 20'd0;
          end else begin
            state_n = RESET_PLL;
            cnt_n   = RST_LOAD;
          end
        end
      end

      STABILIZE: begin
        // Any dropout restarts the wait with a fresh timeout; it is not a
        // failed attempt, so retry_count is left alone.
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = TIMEOUT_LOAD;
        end else if (cnt_zero) begin
          state_n = RUN;
          cnt_n   = 20'd0;
        end
      end

      RUN: begin
        cnt_n = cnt;
        if (!lock_s) begin
`ifdef PLL_SUP_RELOCK_EN
          // Relock: a new full attempt that counts against the cumulative
          // retry total; the limit is enforced when a later WAIT_LOCK times out.
          state_n = RESET_PLL;
          cnt_n   = RST_LOAD;
          retry_n = retry_inc;
`else
          state_n = FAULT;
          cnt_n   = 20'd0;
`endif
        end
      end

      FAULT: begin
        // Sticky until reset_n is asserted.
        cnt_n = cnt;
      end

      default: begin
        state_n = RESET_PLL;
        cnt_n   = RST_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state, so each one changes on the
  // same edge as the state it reflects; core_reset_n drops on the very edge
  // RUN is left, and nothing combinational reaches an output from an input.
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state        <= RESET_PLL;
      cnt          <= RST_INIT;
      retry_count  <= 4'd0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      pll_ready    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      retry_count  <= retry_n;
      pll_rst      <= (state_n == RESET_PLL);
      core_reset_n <= (state_n == RUN);
      pll_ready    <= (state_n == RUN);
      fault        <= (state_n == FAULT);
    end
  end

  assign state_dbg = state;

endmodule
